// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the coordinate type used by the sync
// generator and by every drawing block downstream of it.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic int unsigned seg_total(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // 640x480 @ 60 Hz
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL = seg_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = seg_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: wrapping counter with carry-out, plus registered
// coordinate and sync decoded from the next-state count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE     = DEF_H_VISIBLE,
  parameter int unsigned FP          = DEF_H_FP,
  parameter int unsigned SYNC        = DEF_H_SYNC,
  parameter int unsigned BP          = DEF_H_BP,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output logic   carry,
  output logic   vis_next,
  output coord_t coord,
  output logic   sync
);

  localparam int unsigned TOTAL = seg_total(VISIBLE, FP, SYNC, BP);
  localparam coord_t      LAST  = coord_t'(TOTAL - 1);
  // 11-bit bounds so a segment ending exactly at 1024 still decodes correctly
  localparam logic [COORD_W:0] VIS_END    = (COORD_W+1)'(VISIBLE);
  localparam logic [COORD_W:0] SYNC_START = (COORD_W+1)'(VISIBLE + FP);
  localparam logic [COORD_W:0] SYNC_END   = (COORD_W+1)'(VISIBLE + FP + SYNC);

  coord_t cnt;
  coord_t cnt_next;
  logic   sync_next;

  always_comb begin
    cnt_next = cnt;
    carry    = 1'b0;
    if (en) begin
      if (cnt == LAST) begin
        cnt_next = '0;
        carry    = 1'b1;
      end else begin
        cnt_next = cnt + coord_t'(1);
      end
    end
  end

  assign vis_next  = {1'b0, cnt_next} < VIS_END;
  assign sync_next = ({1'b0, cnt_next} >= SYNC_START && {1'b0, cnt_next} < SYNC_END)
                     ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // cnt parks on LAST in reset so the first enable lands on 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= LAST;
      coord <= '0;
      sync  <= ~SYNC_ACTIVE;
    end else if (en) begin
      cnt   <= cnt_next;
      coord <= cnt_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical axis
// counters and frame_start, all outputs registered on the same edge.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         pix_tick,
  output logic         h_sync,
  output logic         v_sync,
  output logic         video_on,
  output logic [9:0]   pixel_col,
  output logic [9:0]   pixel_row,
  output logic         frame_start
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             h_carry;
  logic             v_carry;
  logic             h_vis_next;
  logic             v_vis_next;

  assign tick = (div_cnt == DIV_LAST);

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .en(tick),
    .carry(h_carry), .vis_next(h_vis_next), .coord(pixel_col), .sync(h_sync)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .en(h_carry),
    .carry(v_carry), .vis_next(v_vis_next), .coord(pixel_row), .sync(v_sync)
  );

  // v_carry only fires alongside h_carry, i.e. exactly when the count enters (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      pix_tick    <= tick;
      frame_start <= v_carry;
      if (tick) video_on <= h_vis_next & v_vis_next;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing for reset/line checks, a shrunken raster for
// frame and mid-frame reset checks, and CLK_DIV=1 / positive-sync variant.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_def, rst_small, rst_fast;

  logic d_tick, d_hs, d_vs, d_vid, d_fs;
  logic [9:0] d_col, d_row;
  logic s_tick, s_hs, s_vs, s_vid, s_fs;
  logic [9:0] s_col, s_row;
  logic f_tick, f_hs, f_vs, f_vid, f_fs;
  logic [9:0] f_col, f_row;

  int errors = 0;
  int checks = 0;

  logic [24:0] pu_trace [40];

  always #5 clk = ~clk;

  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_def), .pix_tick(d_tick), .h_sync(d_hs), .v_sync(d_vs),
    .video_on(d_vid), .pixel_col(d_col), .pixel_row(d_row), .frame_start(d_fs)
  );

  // 15 x 12 raster: h_sync cols 10..12, v_sync rows 7..8, visible 8 x 6
  vga_sync_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_small), .pix_tick(s_tick), .h_sync(s_hs), .v_sync(s_vs),
    .video_on(s_vid), .pixel_col(s_col), .pixel_row(s_row), .frame_start(s_fs)
  );

  // default 800-pixel lines, 12-line frame, one pixel per clk, positive syncs
  vga_sync_gen #(
    .CLK_DIV(1), .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b1)
  ) u_fast (
    .clk(clk), .rst_n(rst_fast), .pix_tick(f_tick), .h_sync(f_hs), .v_sync(f_vs),
    .video_on(f_vid), .pixel_col(f_col), .pixel_row(f_row), .frame_start(f_fs)
  );

  function automatic logic [24:0] pack_small();
    return {s_tick, s_hs, s_vs, s_vid, s_fs, s_col, s_row};
  endfunction

  task automatic test_reset();
    rst_def = 1'b0; rst_small = 1'b0; rst_fast = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (d_tick !== 1'b0) begin errors++; $display("FAIL reset_pix_tick: got %b want 0", d_tick); end
    checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL reset_h_sync: got %b want 1", d_hs); end
    checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL reset_v_sync: got %b want 1", d_vs); end
    checks++; if (d_vid !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %b want 0", d_vid); end
    checks++; if (d_col !== 10'd0) begin errors++; $display("FAIL reset_col: got %0d want 0", d_col); end
    checks++; if (d_row !== 10'd0) begin errors++; $display("FAIL reset_row: got %0d want 0", d_row); end
    checks++; if (d_fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", d_fs); end
    checks++; if (f_hs !== 1'b0) begin errors++; $display("FAIL reset_pos_h_sync: got %b want 0", f_hs); end
    checks++; if (f_vs !== 1'b0) begin errors++; $display("FAIL reset_pos_v_sync: got %b want 0", f_vs); end
    rst_def = 1'b1;
    @(negedge clk);
    checks++; if (d_tick !== 1'b0) begin errors++; $display("FAIL clk1_pix_tick: got %b want 0", d_tick); end
    checks++; if (d_fs !== 1'b0) begin errors++; $display("FAIL clk1_frame_start: got %b want 0", d_fs); end
    @(negedge clk);
    checks++; if (d_tick !== 1'b1) begin errors++; $display("FAIL clk2_pix_tick: got %b want 1", d_tick); end
    checks++; if (d_col !== 10'd0 || d_row !== 10'd0) begin errors++; $display("FAIL clk2_coord: got (%0d,%0d) want (0,0)", d_col, d_row); end
    checks++; if (d_vid !== 1'b1) begin errors++; $display("FAIL clk2_video_on: got %b want 1", d_vid); end
    checks++; if (d_fs !== 1'b1) begin errors++; $display("FAIL clk2_frame_start: got %b want 1", d_fs); end
    checks++; if (d_hs !== 1'b1 || d_vs !== 1'b1) begin errors++; $display("FAIL clk2_syncs: got h=%b v=%b want 1 1", d_hs, d_vs); end
    @(negedge clk);
    checks++; if (d_tick !== 1'b0 || d_fs !== 1'b0) begin errors++; $display("FAIL clk3_pulses: got tick=%b fs=%b want 0 0", d_tick, d_fs); end
  endtask

  task automatic test_line();
    int ticks, clks, hs_low, hs_first, hs_last, vid, coord_err, inv_err, hold_err, wrapped;
    logic [9:0] last_col;
    ticks = 1; clks = 1; hs_low = 0; hs_first = -1; hs_last = -1; vid = 1;
    coord_err = 0; inv_err = 0; hold_err = 0; wrapped = 0; last_col = 10'd0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      clks++;
      if (!d_tick) begin
        if (d_col !== last_col) hold_err++;
      end else begin
        if (d_col == 10'd0) begin wrapped = 1; break; end
        if (d_col !== 10'(ticks) || d_row !== 10'd0) coord_err++;
        if (d_vid !== (d_col < 10'd640 && d_row < 10'd480)) inv_err++;
        if (d_col > 10'd799 || d_row > 10'd524) inv_err++;
        if (d_hs == 1'b0) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_col);
          hs_last = int'(d_col);
        end
        if (d_vid) vid++;
        last_col = d_col;
        ticks++;
      end
    end
    checks++; if (wrapped !== 1) begin errors++; $display("FAIL line_wrap_seen: got %0d want 1", wrapped); end
    checks++; if (ticks !== 800) begin errors++; $display("FAIL line_ticks: got %0d want 800", ticks); end
    checks++; if (clks !== 1600) begin errors++; $display("FAIL line_clks: got %0d want 1600", clks); end
    checks++; if (hs_low !== 96) begin errors++; $display("FAIL line_hsync_len: got %0d want 96", hs_low); end
    checks++; if (hs_first !== 656 || hs_last !== 751) begin errors++; $display("FAIL line_hsync_span: got %0d..%0d want 656..751", hs_first, hs_last); end
    checks++; if (vid !== 640) begin errors++; $display("FAIL line_video_on: got %0d want 640", vid); end
    checks++; if (coord_err !== 0) begin errors++; $display("FAIL line_coords: got %0d bad want 0", coord_err); end
    checks++; if (inv_err !== 0) begin errors++; $display("FAIL line_invariant: got %0d bad want 0", inv_err); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL line_hold: got %0d bad want 0", hold_err); end
    checks++; if (d_row !== 10'd1 || d_fs !== 1'b0 || d_vs !== 1'b1) begin errors++; $display("FAIL line_wrap_state: got row=%0d fs=%b vs=%b want 1 0 1", d_row, d_fs, d_vs); end
  endtask

  task automatic test_frame();
    int clks, ticks, vs_low, vs_rmin, vs_rmax, hs_low, vid, vs_err, inv_err, fs_err, found;
    logic prev_vs;
    rst_small = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pu_trace[i] = pack_small();
    end
    checks++; if (pu_trace[0][24] !== 1'b0) begin errors++; $display("FAIL small_clk1_tick: got %b want 0", pu_trace[0][24]); end
    checks++; if (pu_trace[1] !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin errors++; $display("FAIL small_first_tick: got %h want %h", pu_trace[1], {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0}); end
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (s_fs) begin found = 1; break; end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL frame_start_wait: got %0d want 1", found); end
    clks = 0; ticks = 1; vs_low = 0; vs_rmin = 99; vs_rmax = -1; hs_low = 0; vid = 1;
    vs_err = 0; inv_err = 0; fs_err = 0; found = 0; prev_vs = s_vs;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      clks++;
      if (s_fs) begin
        found = 1;
        if (!(s_tick && s_col == 10'd0 && s_row == 10'd0)) fs_err++;
        break;
      end
      if (s_tick) begin
        ticks++;
        if (s_vid !== (s_col < 10'd8 && s_row < 10'd6)) inv_err++;
        if (s_col > 10'd14 || s_row > 10'd11) inv_err++;
        if (s_vs !== prev_vs && s_col !== 10'd0) vs_err++;
        prev_vs = s_vs;
        if (!s_hs) hs_low++;
        if (!s_vs) begin
          vs_low++;
          if (int'(s_row) < vs_rmin) vs_rmin = int'(s_row);
          if (int'(s_row) > vs_rmax) vs_rmax = int'(s_row);
        end
        if (s_vid) vid++;
      end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL frame_end_seen: got %0d want 1", found); end
    checks++; if (clks !== 360) begin errors++; $display("FAIL frame_clks: got %0d want 360", clks); end
    checks++; if (ticks !== 180) begin errors++; $display("FAIL frame_ticks: got %0d want 180", ticks); end
    checks++; if (vs_low !== 30) begin errors++; $display("FAIL frame_vsync_len: got %0d want 30", vs_low); end
    checks++; if (vs_rmin !== 7 || vs_rmax !== 8) begin errors++; $display("FAIL frame_vsync_rows: got %0d..%0d want 7..8", vs_rmin, vs_rmax); end
    checks++; if (hs_low !== 36) begin errors++; $display("FAIL frame_hsync_len: got %0d want 36", hs_low); end
    checks++; if (vid !== 48) begin errors++; $display("FAIL frame_video_on: got %0d want 48", vid); end
    checks++; if (vs_err !== 0) begin errors++; $display("FAIL frame_vsync_align: got %0d bad want 0", vs_err); end
    checks++; if (inv_err !== 0) begin errors++; $display("FAIL frame_invariant: got %0d bad want 0", inv_err); end
    checks++; if (fs_err !== 0) begin errors++; $display("FAIL frame_wrap_00: got %0d bad want 0", fs_err); end
  endtask

  task automatic test_mid_reset();
    int found, mism;
    logic [24:0] rec;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_tick && s_row == 10'd4 && s_col == 10'd5) begin found = 1; break; end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL mid_reach_4_5: got %0d want 1", found); end
    #2 rst_small = 1'b0;
    #1;
    checks++; if (s_tick !== 1'b0 || s_fs !== 1'b0) begin errors++; $display("FAIL mid_async_pulses: got tick=%b fs=%b want 0 0", s_tick, s_fs); end
    checks++; if (s_col !== 10'd0 || s_row !== 10'd0) begin errors++; $display("FAIL mid_async_coord: got (%0d,%0d) want (0,0)", s_col, s_row); end
    checks++; if (s_vid !== 1'b0 || s_hs !== 1'b1 || s_vs !== 1'b1) begin errors++; $display("FAIL mid_async_levels: got vid=%b hs=%b vs=%b want 0 1 1", s_vid, s_hs, s_vs); end
    @(negedge clk);
    @(negedge clk);
    rst_small = 1'b1;
    mism = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rec = pack_small();
      if (rec !== pu_trace[i]) mism++;
      if (i == 1 && rec !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0}) mism++;
    end
    checks++; if (mism !== 0) begin errors++; $display("FAIL mid_restart_trace: got %0d differing cycles want 0", mism); end
  endtask

  task automatic test_fast();
    int clks, notick, hs_hi, hs_first, hs_last, vs_hi, vid, inv_err, found;
    rst_fast = 1'b1;
    @(negedge clk);
    checks++; if (f_tick !== 1'b1 || f_fs !== 1'b1) begin errors++; $display("FAIL fast_first_pulses: got tick=%b fs=%b want 1 1", f_tick, f_fs); end
    checks++; if (f_col !== 10'd0 || f_row !== 10'd0 || f_vid !== 1'b1) begin errors++; $display("FAIL fast_first_coord: got (%0d,%0d) vid=%b want (0,0) 1", f_col, f_row, f_vid); end
    checks++; if (f_hs !== 1'b0 || f_vs !== 1'b0) begin errors++; $display("FAIL fast_first_syncs: got h=%b v=%b want 0 0", f_hs, f_vs); end
    clks = 0; notick = 0; hs_hi = 0; hs_first = -1; hs_last = -1; vs_hi = 0; vid = 1; inv_err = 0; found = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      clks++;
      if (!f_tick) notick++;
      if (f_fs) begin found = 1; break; end
      if (f_vid !== (f_col < 10'd640 && f_row < 10'd6)) inv_err++;
      if (f_col > 10'd799 || f_row > 10'd11) inv_err++;
      if (f_hs) begin
        hs_hi++;
        if (hs_first < 0 || int'(f_col) < hs_first) hs_first = int'(f_col);
        if (int'(f_col) > hs_last) hs_last = int'(f_col);
      end
      if (f_vs) vs_hi++;
      if (f_vid) vid++;
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL fast_frame_seen: got %0d want 1", found); end
    checks++; if (clks !== 9600) begin errors++; $display("FAIL fast_frame_clks: got %0d want 9600", clks); end
    checks++; if (notick !== 0) begin errors++; $display("FAIL fast_tick_constant: got %0d low cycles want 0", notick); end
    checks++; if (hs_hi !== 1152) begin errors++; $display("FAIL fast_hsync_len: got %0d want 1152", hs_hi); end
    checks++; if (hs_first !== 656 || hs_last !== 751) begin errors++; $display("FAIL fast_hsync_span: got %0d..%0d want 656..751", hs_first, hs_last); end
    checks++; if (vs_hi !== 1600) begin errors++; $display("FAIL fast_vsync_len: got %0d want 1600", vs_hi); end
    checks++; if (vid !== 3840) begin errors++; $display("FAIL fast_video_on: got %0d want 3840", vid); end
    checks++; if (inv_err !== 0) begin errors++; $display("FAIL fast_invariant: got %0d bad want 0", inv_err); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator at the source end of the pixel interface: produces h_sync, v_sync, video_on and the current pixel_row/pixel_col that every drawing block (shape, sprite and colour generators) consumes. Default timing is 640x480 @ 60 Hz from a 25 MHz pixel rate, derived from the system clock by an integer divider. All outputs are registered and mutually aligned, so downstream combinational pixel logic sees a consistent coordinate/sync set.

## Interface
- CLK_DIV, 2, system clocks per pixel (1 = one pixel every clock; 2 = 50 MHz system clock for a 25 MHz pixel rate)
- H_VISIBLE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segment lengths in pixels
- V_VISIBLE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segment lengths in lines
- SYNC_ACTIVE, 0: active level of h_sync/v_sync (0 = negative polarity)

- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- pix_tick  output  1  one-clk pulse per pixel period; counters advance on it
- h_sync  output  1  horizontal sync
- v_sync  output  1  vertical sync
- video_on  output  1  high inside the visible area
- pixel_col  output  10  horizontal count, 0..H_TOTAL-1
- pixel_row  output  10  vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-clk pulse when the count enters (0,0)

## Operation
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be ≤ 1024; counters are 10-bit unsigned and never wrap through overflow.
- Divider: div_cnt counts 0..CLK_DIV-1. pix_tick is asserted in the cycle where div_cnt == CLK_DIV-1, then div_cnt returns to 0. With CLK_DIV = 1, pix_tick is constantly high after reset.
- On pix_tick:
  - h_cnt advances by 1; it wraps to 0 after H_TOTAL-1.
  - On the h wrap, v_cnt advances by 1; it wraps to 0 after V_TOTAL-1.
- Decode from the next-state counters, registered on the same edge:
  - video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
  - h_sync = SYNC_ACTIVE when H_VISIBLE+H_FP ≤ h < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - v_sync = SYNC_ACTIVE when V_VISIBLE+V_FP ≤ v < V_VISIBLE+V_FP+V_SYNC (490..491); otherwise ~SYNC_ACTIVE.
  - pixel_col = h and pixel_row = v at all times, blanking included. Consumers gate their pixel output with video_on.
  - frame_start = 1 for the single clk cycle in which the registered count becomes (0,0).
- Outputs hold their values between ticks.
- v_sync transitions coincide with an h wrap (pixel_col = 0).

## Timing
- Reset (asynchronous on rst_n low):
  - Counters are set to (H_TOTAL-1, V_TOTAL-1); div_cnt = 0.
  - Outputs: pix_tick 0, h_sync and v_sync = ~SYNC_ACTIVE, video_on 0, pixel_col 0, pixel_row 0, frame_start 0.
- First tick after release: pix_tick is high in clk cycle CLK_DIV after rst_n rises. On that edge the outputs show (0,0), video_on = 1 and frame_start = 1.
- Latency: outputs update on the same clk edge that pix_tick qualifies. There is zero skew between coordinates, syncs and video_on.
- Periods: line = H_TOTAL·CLK_DIV clks (1600); frame = H_TOTAL·V_TOTAL·CLK_DIV clks (840 000 at defaults, 60 Hz from 50 MHz).
- Reset mid-frame: every output goes immediately to its reset value; the restart is identical to power-up. No partial line is emitted.
- Simultaneous h and v wrap: resolves to (0,0) in one tick, with frame_start.

## Structure
- Package vga_timing_pkg holds:
  - default segment constants;
  - derived H_TOTAL/V_TOTAL and sync start/end constants;
  - the 10-bit coordinate typedef, shared with the drawing blocks.
- Sub-module vga_axis_counter:
  - a parameterised wrapping counter with enable, carry-out and sync/visible decode;
  - instantiated twice. Horizontal: enable = pix_tick. Vertical: enable = horizontal carry.
- The divider and frame_start logic stay in the top.

## Test plan
- Reset, then release with CLK_DIV=2 → every output at its reset value; first pix_tick at clk 2 with pixel_col=0, pixel_row=0, video_on=1, frame_start=1.
- Run one line → exactly 800 ticks; h_sync low for ticks 656..751 (96 ticks); video_on high for ticks 0..639; pixel_col wraps 799→0 while pixel_row increments.
- Run one full frame → frame_start pulses exactly 840 000 clks apart; v_sync low on lines 490..491 (1600 ticks); video_on high for 307 200 ticks per frame.
- Assert rst_n low at pixel_row=300, pixel_col=400 → outputs reset asynchronously without waiting for clk; after release the sequence is identical to power-up.
- CLK_DIV=1 and SYNC_ACTIVE=1 → pix_tick is constantly high; frame = 420 000 clks; h_sync high only for cols 656..751.
- Checker on every tick: video_on == (pixel_col<640 && pixel_row<480); pixel_col ≤ 799; pixel_row ≤ 524.
